// File: rtl/instr_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// instr_loader
//
// Program loader between a UART receiver and the instruction memory write
// port. A frame is a count byte N (0 means 256) followed by 4*N data bytes.
// Each group of four bytes is packed little-endian into a 32-bit word and
// written to the instruction memory at word addresses 0, 1, 2, ...
// The CPU is held in reset from power-up, while a frame is being received,
// and after any failed load; it is released only by a successful load.
//
// Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//   the frame carries one trailing byte equal to the XOR of all data bytes.
//   A mismatching checksum sets err and keeps the CPU held.
//
// Parameters
//   TIMEOUT_CYCLES : idle clocks allowed between bytes inside a frame.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   rx_valid in   one-cycle strobe qualifying rx_data
//   rx_data  in   received byte [7:0]
//   we       out  instruction memory write enable, one pulse per word
//   addr_a   out  instruction memory word address [7:0]
//   din_a    out  instruction word [31:0]
//   cpu_hold out  high holds the CPU in reset
//   busy     out  high while a frame is in progress
//   done     out  one-cycle pulse on successful load
//   err      out  sticky abort flag, cleared by the next count byte
// ---------------------------------------------------------------------------
module instr_loader #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        we,
    output logic [7:0]  addr_a,
    output logic [31:0] din_a,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // The timeout counter only ever needs to reach TIMEOUT_CYCLES-1: the
    // cycle on which it would reach TIMEOUT_CYCLES is the abort cycle.
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_CHECK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1
    } state_t;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [8:0]         r_words_left;   // words still to receive, 1..256
    logic [1:0]         r_byte_idx;     // byte lane of the next data byte
    logic [7:0]         r_word_idx;     // address of the word being built
    logic [23:0]        r_shift;        // lanes 0..2 of the word being built
    logic [TMO_W-1:0]   r_tmo;          // idle clocks since the last byte
    logic               r_we;
    logic [7:0]         r_addr;
    logic [31:0]        r_din;
    logic               r_hold;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         r_acc;          // running XOR of data bytes
`endif

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [8:0]         w_words_nxt;
    logic [1:0]         w_byte_idx_nxt;
    logic [7:0]         w_word_idx_nxt;
    logic [23:0]        w_shift_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic               w_we_nxt;
    logic [7:0]         w_addr_nxt;
    logic [31:0]        w_din_nxt;
    logic               w_hold_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         w_acc_nxt;
`endif
    logic               w_tmo_hit;

    // A byte arriving on the would-be timeout cycle wins, hence !rx_valid.
    assign w_tmo_hit = (r_state != S_IDLE) && !rx_valid && (r_tmo == TMO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_words_left <= 9'd0;
            r_byte_idx   <= 2'd0;
            r_word_idx   <= 8'd0;
            r_shift      <= 24'd0;
            r_tmo        <= '0;
            r_we         <= 1'b0;
            r_addr       <= 8'd0;
            r_din        <= 32'd0;
            r_hold       <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_acc        <= 8'd0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_words_left <= w_words_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_word_idx   <= w_word_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_tmo        <= w_tmo_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_din        <= w_din_nxt;
            r_hold       <= w_hold_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
`ifdef LOADER_CHECKSUM_EN
            r_acc        <= w_acc_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_words_nxt    = r_words_left;
        w_byte_idx_nxt = r_byte_idx;
        w_word_idx_nxt = r_word_idx;
        w_shift_nxt    = r_shift;
        w_we_nxt       = 1'b0;
        w_addr_nxt     = r_addr;
        w_din_nxt      = r_din;
        w_hold_nxt     = r_hold;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;
`ifdef LOADER_CHECKSUM_EN
        w_acc_nxt      = r_acc;
`endif
        // Counter restarts on every byte and is parked at zero in IDLE.
        if ((r_state == S_IDLE) || rx_valid) begin
            w_tmo_nxt = '0;
        end else begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_state_nxt    = S_DATA;
                    w_words_nxt    = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    w_byte_idx_nxt = 2'd0;
                    w_word_idx_nxt = 8'd0;
                    w_err_nxt      = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_hold_nxt     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    w_acc_nxt      = 8'd0;
`endif
                end
            end

            S_DATA: begin
                if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    w_acc_nxt = r_acc ^ rx_data;
`endif
                    w_byte_idx_nxt = r_byte_idx + 2'd1;
                    case (r_byte_idx)
                        2'd0: w_shift_nxt[7:0]   = rx_data;
                        2'd1: w_shift_nxt[15:8]  = rx_data;
                        2'd2: w_shift_nxt[23:16] = rx_data;
                        default: begin
                            // Lane 3 completes the word; write it next cycle.
                            w_we_nxt       = 1'b1;
                            w_addr_nxt     = r_word_idx;
                            w_din_nxt      = {rx_data, r_shift};
                            w_word_idx_nxt = r_word_idx + 8'd1;
                            w_words_nxt    = r_words_left - 9'd1;
                            if (r_words_left == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                w_state_nxt = S_CHECK;
`else
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                                w_hold_nxt  = 1'b0;
                                w_busy_nxt  = 1'b0;
`endif
                            end
                        end
                    endcase
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (rx_valid) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    if (rx_data == r_acc) begin
                        w_done_nxt = 1'b1;
                        w_hold_nxt = 1'b0;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_hold_nxt = 1'b1;
                    end
                end
            end
`endif

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort: only reachable with no byte this cycle, so nothing above
        // has issued a write; a partially assembled word is discarded.
        if (w_tmo_hit) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
            w_hold_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_tmo_nxt   = '0;
        end
    end

    assign we       = r_we;
    assign addr_a   = r_addr;
    assign din_a    = r_din;
    assign cpu_hold = r_hold;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_instr_loader.sv
`timescale 1ns/1ps
module tb_instr_loader;

    localparam int T = 40;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        we;
    logic [7:0]  addr_a;
    logic [31:0] din_a;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          done_cnt = 0;
    logic [7:0]  cks;

    instr_loader #(.TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .we       (we),
        .addr_a   (addr_a),
        .din_a    (din_a),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_addr_q.push_back(addr_a);
            wr_data_q.push_back(din_a);
        end
        if (done === 1'b1) done_cnt++;
    end

    // Entered and left on a falling edge: one byte strobe per call.
    task automatic drive(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic [7:0] n);
        cks = 8'h00;
        drive(n);
    endtask

    task automatic data_byte(input logic [7:0] b);
        cks = cks ^ b;
        drive(b);
    endtask

    task automatic end_frame();
`ifdef LOADER_CHECKSUM_EN
        drive(cks);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        idle(3);
        n_checks++; if (we !== 1'b0)        begin $display("FAIL rst_we got %b exp 0", we); n_fail++; end
        n_checks++; if (addr_a !== 8'h00)   begin $display("FAIL rst_addr got %h exp 00", addr_a); n_fail++; end
        n_checks++; if (din_a !== 32'h0)    begin $display("FAIL rst_din got %h exp 0", din_a); n_fail++; end
        n_checks++; if (cpu_hold !== 1'b1)  begin $display("FAIL rst_hold got %b exp 1", cpu_hold); n_fail++; end
        n_checks++; if (busy !== 1'b0)      begin $display("FAIL rst_busy got %b exp 0", busy); n_fail++; end
        n_checks++; if (done !== 1'b0)      begin $display("FAIL rst_done got %b exp 0", done); n_fail++; end
        n_checks++; if (err !== 1'b0)       begin $display("FAIL rst_err got %b exp 0", err); n_fail++; end
        rst = 1'b0;
        idle(2);
        n_checks++; if (cpu_hold !== 1'b1)  begin $display("FAIL hold_after_rst got %b exp 1", cpu_hold); n_fail++; end
    endtask

    task automatic test_single_word();
        int wb = wr_addr_q.size();
        int db = done_cnt;
        start_frame(8'd1);
        n_checks++; if (busy !== 1'b1)      begin $display("FAIL sw_busy got %b exp 1", busy); n_fail++; end
        data_byte(8'h13); data_byte(8'h00); data_byte(8'h00); data_byte(8'h00);
        n_checks++; if (we !== 1'b1)        begin $display("FAIL sw_we got %b exp 1", we); n_fail++; end
        n_checks++; if (addr_a !== 8'h00)   begin $display("FAIL sw_addr got %h exp 00", addr_a); n_fail++; end
        n_checks++; if (din_a !== 32'h00000013) begin $display("FAIL sw_din got %h exp 00000013", din_a); n_fail++; end
        end_frame();
        n_checks++; if (done !== 1'b1)      begin $display("FAIL sw_done got %b exp 1", done); n_fail++; end
        n_checks++; if (cpu_hold !== 1'b0)  begin $display("FAIL sw_hold got %b exp 0", cpu_hold); n_fail++; end
        n_checks++; if (busy !== 1'b0)      begin $display("FAIL sw_busy_end got %b exp 0", busy); n_fail++; end
        idle(2);
        n_checks++; if (we !== 1'b0)        begin $display("FAIL sw_we_pulse got %b exp 0", we); n_fail++; end
        n_checks++; if (din_a !== 32'h00000013) begin $display("FAIL sw_din_hold got %h exp 00000013", din_a); n_fail++; end
        n_checks++; if (wr_addr_q.size() - wb !== 1) begin $display("FAIL sw_nwrites got %0d exp 1", wr_addr_q.size() - wb); n_fail++; end
        n_checks++; if (done_cnt - db !== 1) begin $display("FAIL sw_ndone got %0d exp 1", done_cnt - db); n_fail++; end
    endtask

    task automatic test_full_wrap();
        int wb = wr_addr_q.size();
        int db = done_cnt;
        int bad = 0;
        start_frame(8'd0);
        for (int k = 0; k < 256; k++) begin
            data_byte(k[7:0]); data_byte(8'h00); data_byte(8'h00); data_byte(8'h00);
        end
        end_frame();
        idle(2);
        n_checks++; if (wr_addr_q.size() - wb !== 256) begin $display("FAIL wrap_nwrites got %0d exp 256", wr_addr_q.size() - wb); n_fail++; end
        if (wr_addr_q.size() - wb == 256) begin
            for (int k = 0; k < 256; k++) begin
                if (wr_addr_q[wb + k] !== k[7:0] || wr_data_q[wb + k] !== k) begin
                    if (bad == 0) $display("FAIL wrap_word %0d got addr %h data %h exp addr %h data %h",
                                           k, wr_addr_q[wb + k], wr_data_q[wb + k], k[7:0], k);
                    bad++;
                end
            end
        end
        n_checks++; if (bad !== 0)          begin $display("FAIL wrap_bad_words got %0d exp 0", bad); n_fail++; end
        n_checks++; if (done_cnt - db !== 1) begin $display("FAIL wrap_ndone got %0d exp 1", done_cnt - db); n_fail++; end
        n_checks++; if (addr_a !== 8'hFF)   begin $display("FAIL wrap_addr_end got %h exp ff", addr_a); n_fail++; end
        n_checks++; if (cpu_hold !== 1'b0)  begin $display("FAIL wrap_hold got %b exp 0", cpu_hold); n_fail++; end
    endtask

    task automatic test_timeout();
        int wb = wr_addr_q.size();
        int db = done_cnt;
        start_frame(8'd2);
        idle(3); data_byte(8'hAA);
        idle(3); data_byte(8'hBB);
        idle(3); data_byte(8'hCC);
        idle(3); data_byte(8'hDD);
        idle(3); data_byte(8'hEE);
        idle(T - 5);
        n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin $display("FAIL tmo_early got err %b busy %b exp err 0 busy 1", err, busy); n_fail++; end
        idle(10);
        n_checks++; if (err !== 1'b1)       begin $display("FAIL tmo_err got %b exp 1", err); n_fail++; end
        n_checks++; if (busy !== 1'b0)      begin $display("FAIL tmo_busy got %b exp 0", busy); n_fail++; end
        n_checks++; if (cpu_hold !== 1'b1)  begin $display("FAIL tmo_hold got %b exp 1", cpu_hold); n_fail++; end
        n_checks++; if (wr_addr_q.size() - wb !== 1) begin $display("FAIL tmo_nwrites got %0d exp 1", wr_addr_q.size() - wb); n_fail++; end
        if (wr_addr_q.size() - wb >= 1) begin
            n_checks++; if (wr_data_q[wb] !== 32'hDDCCBBAA || wr_addr_q[wb] !== 8'h00) begin
                $display("FAIL tmo_word got addr %h data %h exp addr 00 data ddccbbaa", wr_addr_q[wb], wr_data_q[wb]); n_fail++; end
        end
        n_checks++; if (done_cnt - db !== 0) begin $display("FAIL tmo_ndone got %0d exp 0", done_cnt - db); n_fail++; end
    endtask

    task automatic test_back_to_back();
        int wb = wr_addr_q.size();
        int db = done_cnt;
        n_checks++; if (err !== 1'b1)       begin $display("FAIL b2b_pre_err got %b exp 1", err); n_fail++; end
        start_frame(8'd1);
        n_checks++; if (err !== 1'b0)       begin $display("FAIL b2b_err_clr got %b exp 0", err); n_fail++; end
        data_byte(8'h78); data_byte(8'h56); data_byte(8'h34); data_byte(8'h12);
        n_checks++; if (we !== 1'b1 || din_a !== 32'h12345678) begin $display("FAIL b2b_write got we %b din %h exp we 1 din 12345678", we, din_a); n_fail++; end
        end_frame();
        idle(2);
        n_checks++; if (wr_addr_q.size() - wb !== 1) begin $display("FAIL b2b_nwrites got %0d exp 1", wr_addr_q.size() - wb); n_fail++; end
        n_checks++; if (done_cnt - db !== 1) begin $display("FAIL b2b_ndone got %0d exp 1", done_cnt - db); n_fail++; end
        n_checks++; if (cpu_hold !== 1'b0 || err !== 1'b0) begin $display("FAIL b2b_end got hold %b err %b exp 0 0", cpu_hold, err); n_fail++; end
    endtask

    // Gaps of T-1 idle clocks put each byte on the would-be abort cycle.
    task automatic test_timeout_edge();
        int db = done_cnt;
        start_frame(8'd1);
        n_checks++; if (cpu_hold !== 1'b1)  begin $display("FAIL edge_reload_hold got %b exp 1", cpu_hold); n_fail++; end
        idle(T - 1); data_byte(8'hEF);
        idle(T - 1); data_byte(8'hBE);
        idle(T - 1); data_byte(8'hAD);
        idle(T - 1); data_byte(8'hDE);
        n_checks++; if (we !== 1'b1 || din_a !== 32'hDEADBEEF) begin $display("FAIL edge_write got we %b din %h exp we 1 din deadbeef", we, din_a); n_fail++; end
        end_frame();
        idle(2);
        n_checks++; if (err !== 1'b0)       begin $display("FAIL edge_err got %b exp 0", err); n_fail++; end
        n_checks++; if (done_cnt - db !== 1) begin $display("FAIL edge_ndone got %0d exp 1", done_cnt - db); n_fail++; end
    endtask

    task automatic test_reset_mid_frame();
        int wb;
        int db;
        start_frame(8'd3);
        data_byte(8'h11); data_byte(8'h22);
        rst = 1'b1;
        #1;
        n_checks++; if (we !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b0 || din_a !== 32'h0 || addr_a !== 8'h00)
            begin $display("FAIL rstmid_outs got we %b hold %b busy %b din %h addr %h exp 0 1 0 0 0", we, cpu_hold, busy, din_a, addr_a); n_fail++; end
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        wb = wr_addr_q.size();
        db = done_cnt;
        start_frame(8'd1);
        data_byte(8'h44); data_byte(8'h33); data_byte(8'h22); data_byte(8'h11);
        end_frame();
        idle(2);
        n_checks++; if (wr_addr_q.size() - wb !== 1) begin $display("FAIL rstmid_nwrites got %0d exp 1", wr_addr_q.size() - wb); n_fail++; end
        if (wr_addr_q.size() - wb >= 1) begin
            n_checks++; if (wr_addr_q[wb] !== 8'h00 || wr_data_q[wb] !== 32'h11223344) begin
                $display("FAIL rstmid_word got addr %h data %h exp addr 00 data 11223344", wr_addr_q[wb], wr_data_q[wb]); n_fail++; end
        end
        n_checks++; if (done_cnt - db !== 1 || cpu_hold !== 1'b0) begin $display("FAIL rstmid_done got %0d hold %b exp 1 0", done_cnt - db, cpu_hold); n_fail++; end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        drive(8'd1); drive(8'h01); drive(8'h02); drive(8'h04); drive(8'h08); drive(8'h0F);
        n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin $display("FAIL cks_good got done %b hold %b exp 1 0", done, cpu_hold); n_fail++; end
        idle(2);
        drive(8'd1); drive(8'h01); drive(8'h02); drive(8'h04); drive(8'h08); drive(8'h0E);
        n_checks++; if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin $display("FAIL cks_bad got err %b hold %b done %b exp 1 1 0", err, cpu_hold, done); n_fail++; end
        idle(2);
    endtask
`endif

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        cks = 8'h00;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_full_wrap();
        test_timeout();
        test_back_to_back();
        test_timeout_edge();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-stream program loader that sequences writes into the instruction memory's write port (`we`/`addr_a`/`din_a`) from a UART receiver byte stream. It decodes a length-prefixed frame, packs little-endian bytes into 32-bit words, and issues one write per word at incrementing addresses. It also holds the CPU in reset while a load is in progress or has failed. It sits between the UART RX block and the instruction memory, with `cpu_hold` driving the core's reset.

## Interface

- `TIMEOUT_CYCLES`, default 1000000: maximum idle clocks between bytes inside a frame before the load is aborted.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `rx_valid` input 1: one-cycle strobe; `rx_data` is valid on this cycle.
- `rx_data` input 8: received byte.
- `we` output 1: instruction memory write enable; one-cycle pulse per word.
- `addr_a` output 8: instruction memory word address.
- `din_a` output 32: instruction word to write.
- `cpu_hold` output 1: high holds the CPU in reset.
- `busy` output 1: high while a frame is in progress.
- `done` output 1: one-cycle pulse when a load completes successfully.
- `err` output 1: sticky flag set on abort; cleared when the next frame starts.

## Operation

- **Frame format:** count byte N, then 4·N data bytes.
  - Each word is sent LSB first.
  - N=0 means 256 words.
  - With `LOADER_CHECKSUM_EN`, one checksum byte follows the data bytes.
- **States:** IDLE, DATA, CHECK (CHECK exists only with the macro).
- **IDLE:** `rx_valid` latches N into the word counter and moves to DATA.
  - Same cycle: `err` clears, `busy` and `cpu_hold` rise, the byte index and word address reset to 0, and the checksum accumulator clears.
- **DATA:** each `rx_valid` shifts the byte into the word register at byte lane = byte index (0..3) and XORs it into the accumulator.
  - On lane 3, the completed word is registered to `din_a`, `addr_a` is set to the word index, and `we` is pulsed the next cycle.
  - The word index then increments, wrapping at 256.
- **End of data:**
  - Without the macro: after the Nth word, go to IDLE, pulse `done`, drop `cpu_hold` and `busy`.
  - With the macro: after the Nth word, go to CHECK.
- **CHECK:** the next `rx_valid` compares the byte to the accumulator.
  - Match: `done` pulses, `cpu_hold` and `busy` drop.
  - Mismatch: `err` is set, `cpu_hold` stays high.
  - Either way, return to IDLE.
- **Timeout:** the timeout counter resets on every `rx_valid` and counts while not in IDLE.
  - Reaching `TIMEOUT_CYCLES`: go to IDLE, set `err`, keep `cpu_hold` high, drop `busy`.
  - No write is issued for a partially assembled word.
- **Failed loads:** words already written stay in memory. The CPU stays held until a later frame succeeds.
- **Reload:** a new frame after a successful load re-asserts `cpu_hold` on its count byte.

## Timing

- **Reset values:** `we`=0, `addr_a`=0, `din_a`=0, `cpu_hold`=1, `busy`=0, `done`=0, `err`=0; state IDLE.
  - The CPU is held from power-up until the first successful load.
- **Write latency:** `we` is high exactly one cycle, on the cycle after the 4th byte's `rx_valid`.
  - `addr_a` and `din_a` are stable during that cycle and hold afterwards.
- **Completion (no macro):** `done`, `cpu_hold` fall and `busy` fall are all one cycle after the last data byte, coincident with the final `we`.
- **Completion (macro):** one cycle after the checksum byte's `rx_valid`.
- **Back-to-back bytes:** `rx_valid` on consecutive cycles must be accepted with no loss; the write pipeline never stalls input.
- **`rx_valid` on the timeout cycle:** the byte wins; it is accepted and the timeout counter resets.
- **Reset mid-frame:** all outputs return to reset values immediately; a pending `we` is dropped.

## Configuration

- **`LOADER_CHECKSUM_EN` defined:** the frame carries a trailing XOR-of-all-data-bytes checksum.
  - The CHECK state and the accumulator exist.
  - A mismatch sets `err` and keeps the CPU held.
- **Undefined:** no checksum byte is expected.
  - The CHECK state and the accumulator are not built.
  - The load completes after the last data byte.

## Test plan

- **Single word:** send N=1, bytes 13,00,00,00 (hex). Expect one `we` pulse with `addr_a`=0, `din_a`=0x00000013; `done` pulses; `cpu_hold` goes 1→0.
- **Full memory with wrap:** send N=0 and 1024 bytes where word k = k. Expect 256 writes at addresses 0..255 with `din_a`=k; `done` pulses once; `addr_a` ends at 255.
- **Timeout:** send N=2 and 5 bytes, then idle for `TIMEOUT_CYCLES`. Expect 1 write only; `err`=1; `busy`=0; `cpu_hold`=1; no `done`.
- **Back-to-back after error:** with `err`=1, send N=1 and 4 bytes on consecutive cycles. Expect `err` cleared on the count byte; 1 write; `done` pulses.
- **Checksum (macro on):** send N=1, bytes 01,02,04,08.
  - Checksum 0F: expect `done`, `cpu_hold`=0.
  - Checksum 0E: expect `err`=1, `cpu_hold`=1.
- **Reset mid-frame:** assert `rst` after the 2nd data byte. Expect `we`=0, `cpu_hold`=1, state IDLE; the next frame loads starting at address 0.
